mest_pro_output_seq: RTL and testbench
======================================

# mest_pro_output_seq

Output sequencer that sits directly upstream of the 7-segment output decoder. On a start pulse it reads a block of words from the output memory through a single-cycle-latency read port. It splits each word into 4-bit digits, most significant first, and presents each digit on `o_mem_val` with `o_output_enable` high for a fixed dwell time. Enable is held low for a blanking gap between digits.

## Interface
Parameters:
- `DATA_WIDTH`, 16: output-memory word width; must be a multiple of 4; `NIB = DATA_WIDTH/4` digits per word.
- `ADDR_WIDTH`, 4: output-memory address width.
- `DWELL`, 8: cycles each digit is shown with enable high; must be ≥1.
- `GAP`, 2: blank cycles (enable low) after each digit; 0 disables the gap state.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_start`  in  1  start request; sampled only in IDLE.
- `i_base_addr`  in  ADDR_WIDTH  first word address; latched on accepted start.
- `i_count`  in  ADDR_WIDTH  number of words to show; latched on accepted start.
- `o_rd_en`  out  1  memory read strobe.
- `o_rd_addr`  out  ADDR_WIDTH  memory read address.
- `i_rd_data`  in  DATA_WIDTH  read data; valid the cycle after `o_rd_en`.
- `o_mem_val`  out  4  digit to the decoder.
- `o_output_enable`  out  1  decoder enable; low blanks the display.
- `o_busy`  out  1  high in every state except IDLE.
- `o_done`  out  1  one-cycle pulse when the sequence ends.

## Operation
- All outputs are registered. On reset every output is 0, the state is IDLE, and all counters and latches are 0.
- States: IDLE, FETCH, WAIT, SHOW, GAP, DONE.
- **IDLE**
  - `i_start=1` latches base and count, then goes to FETCH.
  - If the latched count is 0, it goes straight to DONE instead.
- **FETCH** (1 cycle): `o_rd_en=1`, `o_rd_addr`=current address, then WAIT.
- **WAIT** (1 cycle)
  - Captures `i_rd_data` into the word register and sets the digit index to `NIB-1`.
  - Then goes to SHOW.
- **SHOW** (`DWELL` cycles)
  - `o_output_enable=1` and `o_mem_val=word[4*idx+3:4*idx]`.
  - Then goes to GAP, or directly to the next-step decision if `GAP=0`.
- **GAP** (`GAP` cycles): `o_output_enable=0` and `o_mem_val=0`.
- Next-step decision after each digit:
  - If idx > 0: decrement idx and go to SHOW.
  - Else, if words remain: increment the address and go to FETCH.
  - Else: go to DONE.
- **DONE** (1 cycle): `o_done=1`, then IDLE.
- Address arithmetic is modulo 2^ADDR_WIDTH. Reading past the top address wraps to 0.
- `o_rd_en` is 0 in every state except FETCH. `o_rd_addr` holds its last value outside FETCH.
- `i_start` is ignored while `o_busy=1`, including in DONE. `i_base_addr` and `i_count` changes after acceptance have no effect.
- `rst` has priority over everything.
  - Asserted mid-sequence, it returns to IDLE on the next edge and zeroes all outputs, with no `o_done`.
  - `i_start` in the same cycle as `rst` is discarded.

## Timing
- Let cycle 0 be the cycle in which `i_start` is sampled high in IDLE.
- Cycle 1: FETCH, with `o_rd_en=1` and `o_busy=1`.
- Cycle 2: WAIT. Data is captured at the end of cycle 2.
- Per-word cost is `2 + NIB*(DWELL+GAP)` cycles.
- The `o_done` pulse occurs in cycle `1 + count*(2 + NIB*(DWELL+GAP))`, and `o_busy` falls in the following cycle.
- With `count=0`: `o_done=1` and `o_busy=1` in cycle 1, no read is issued, and IDLE resumes in cycle 2.
- The decoder adds one further register stage. The displayed segments lag `o_mem_val` and `o_output_enable` by one cycle; this block does not compensate.
- A new start is accepted at the earliest in the cycle after DONE.

## Test plan
- **Single word:** defaults, mem[3]=16'h1A2F, start with base=3, count=1.
  - `o_rd_en` high in cycle 1 only, with addr 3.
  - Enable high in cycles 3–10 (val 1), 13–20 (val A), 23–30 (val 2) and 33–40 (val F).
  - Enable low in cycles 11–12, 21–22, 31–32 and 41–42.
  - `o_done` in cycle 43.
- **Wrap-around:** base=15, count=2.
  - Reads addr 15 in cycle 1 and addr 0 in cycle 43.
  - `o_done` in cycle 85.
- **Zero count:** start with count=0.
  - `o_done` in cycle 1 and `o_rd_en` never asserted.
  - `o_busy` high only in cycle 1.
- **Start while busy:** assert `i_start` with a different base in cycles 5 and 43 of a count=1 run.
  - Both are ignored: no extra reads and a single `o_done`.
  - A start in cycle 44 is accepted.
- **Reset mid-show:** assert `rst` in cycle 15 of a count=1 run.
  - Cycle 16: all outputs 0, state IDLE, no `o_done`.
  - A subsequent start replays from the first digit.
- **GAP=0, DWELL=1:** word 16'h4321.
  - Values 4, 3, 2, 1 with enable high in consecutive cycles 3–6.
  - `o_done` in cycle 7.

Source files
------------

// File: rtl/mest_pro_output_seq.sv
`default_nettype none
// == mest_pro_output_seq: reads words from output memory and shows them as dwell/gap-timed 4-bit digits, MSB first (rev 1.0) ==
module mest_pro_output_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int DWELL      = 8,
  parameter int GAP        = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH-1:0] i_count,
  output logic                  o_rd_en,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic [3:0]            o_mem_val,
  output logic                  o_output_enable,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int NIB     = DATA_WIDTH / 4;
  localparam int IDX_W   = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int CNT_MAX = (DWELL > GAP) ? DWELL : GAP;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_TOP    = IDX_W'(NIB - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_SHOW  = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] addr, addr_n;
  logic [ADDR_WIDTH-1:0] rem, rem_n;
  logic [DATA_WIDTH-1:0] word, word_n;
  logic [IDX_W-1:0]      idx, idx_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic                  advance;
  logic [3:0]            digit_n;

  always_comb begin
    state_n = state;
    addr_n  = addr;
    rem_n   = rem;
    word_n  = word;
    idx_n   = idx;
    cnt_n   = cnt;
    advance = 1'b0;

    case (state)
      S_IDLE: begin
        if (i_start) begin
          addr_n  = i_base_addr;
          rem_n   = i_count;
          state_n = (i_count == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: state_n = S_WAIT;
      S_WAIT: begin
        word_n  = i_rd_data;
        idx_n   = IDX_TOP;
        cnt_n   = '0;
        state_n = S_SHOW;
      end
      S_SHOW: begin
        if (cnt == DWELL_LAST) begin
          cnt_n = '0;
          if (GAP > 0) state_n = S_GAP;
          else         advance = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_n   = '0;
          advance = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // End of a digit: next digit of this word, next word, or finish
    if (advance) begin
      if (idx != '0) begin
        idx_n   = idx - IDX_W'(1);
        state_n = S_SHOW;
      end else if (rem > ADDR_WIDTH'(1)) begin
        addr_n  = addr + ADDR_WIDTH'(1);
        rem_n   = rem - ADDR_WIDTH'(1);
        state_n = S_FETCH;
      end else begin
        state_n = S_DONE;
      end
    end
  end

  // Outputs are registered from next-state values so they line up with the state they describe
  assign digit_n = 4'(word_n >> {idx_n, 2'b00});

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      addr            <= '0;
      rem             <= '0;
      word            <= '0;
      idx             <= '0;
      cnt             <= '0;
      o_rd_en         <= 1'b0;
      o_rd_addr       <= '0;
      o_mem_val       <= '0;
      o_output_enable <= 1'b0;
      o_busy          <= 1'b0;
      o_done          <= 1'b0;
    end else begin
      state           <= state_n;
      addr            <= addr_n;
      rem             <= rem_n;
      word            <= word_n;
      idx             <= idx_n;
      cnt             <= cnt_n;
      o_rd_en         <= (state_n == S_FETCH);
      if (state_n == S_FETCH) o_rd_addr <= addr_n;
      o_mem_val       <= (state_n == S_SHOW) ? digit_n : 4'h0;
      o_output_enable <= (state_n == S_SHOW);
      o_busy          <= (state_n != S_IDLE);
      o_done          <= (state_n == S_DONE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mest_pro_output_seq.sv
`default_nettype none
// == tb_mest_pro_output_seq: randomized trace comparison of the output sequencer against a digit-stream model (rev 1.0) ==
module tb_mest_pro_output_seq;

  logic        clk;
  logic        rst;
  logic        start1, start2;
  logic [3:0]  base1, cnt1, base2, cnt2;
  logic        rd_en1, rd_en2;
  logic [3:0]  rd_addr1, rd_addr2;
  logic [15:0] rd_data1, rd_data2;
  logic [3:0]  val1, val2;
  logic        oe1, oe2, busy1, busy2, done1, done2;
  logic [11:0] obs1, obs2;

  logic [15:0] mem [16];
  logic [11:0] exp_q [$];
  logic [3:0]  last1, last2;
  int          checks, passed;

  mest_pro_output_seq dut (
    .clk(clk), .rst(rst), .i_start(start1), .i_base_addr(base1), .i_count(cnt1),
    .o_rd_en(rd_en1), .o_rd_addr(rd_addr1), .i_rd_data(rd_data1),
    .o_mem_val(val1), .o_output_enable(oe1), .o_busy(busy1), .o_done(done1)
  );

  mest_pro_output_seq #(.DWELL(1), .GAP(0)) dut_fast (
    .clk(clk), .rst(rst), .i_start(start2), .i_base_addr(base2), .i_count(cnt2),
    .o_rd_en(rd_en2), .o_rd_addr(rd_addr2), .i_rd_data(rd_data2),
    .o_mem_val(val2), .o_output_enable(oe2), .o_busy(busy2), .o_done(done2)
  );

  assign obs1 = {rd_en1, rd_addr1, oe1, val1, busy1, done1};
  assign obs2 = {rd_en2, rd_addr2, oe2, val2, busy2, done2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-cycle-latency output memory, one read port per instance
  always @(posedge clk) begin
    if (rd_en1) rd_data1 <= mem[rd_addr1];
    if (rd_en2) rd_data2 <= mem[rd_addr2];
  end

  // Expected output trace from cycle 1: per word one read cycle, one wait cycle,
  // then each digit MSB first shown for dwell cycles and blanked for gap cycles,
  // then a single done cycle and one idle cycle.
  task automatic build(input int dwell, input int gap, input logic [3:0] base,
                       input logic [3:0] cnt, inout logic [3:0] last);
    exp_q.delete();
    for (int w = 0; w < int'(cnt); w++) begin
      logic [3:0]  a;
      logic [15:0] word;
      a    = base + 4'(w);
      word = mem[a];
      last = a;
      exp_q.push_back({1'b1, a, 1'b0, 4'h0, 1'b1, 1'b0});
      exp_q.push_back({1'b0, a, 1'b0, 4'h0, 1'b1, 1'b0});
      for (int d = 3; d >= 0; d--) begin
        for (int k = 0; k < dwell; k++) exp_q.push_back({1'b0, a, 1'b1, word[4*d +: 4], 1'b1, 1'b0});
        for (int k = 0; k < gap; k++)   exp_q.push_back({1'b0, a, 1'b0, 4'h0, 1'b1, 1'b0});
      end
    end
    exp_q.push_back({1'b0, last, 1'b0, 4'h0, 1'b1, 1'b1});
    exp_q.push_back({1'b0, last, 1'b0, 4'h0, 1'b0, 1'b0});
  endtask

  task automatic fill_mem_random();
    for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1; start1 = 1'b1; base1 = 4'd7; cnt1 = 4'd2;
    start2 = 1'b1; base2 = 4'd9; cnt2 = 4'd1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs1 !== 12'h000) $display("FAIL reset_dut: got %h expected %h", obs1, 12'h000);
    else passed++;
    checks++;
    if (obs2 !== 12'h000) $display("FAIL reset_dut_fast: got %h expected %h", obs2, 12'h000);
    else passed++;
    rst = 1'b0; start1 = 1'b0; start2 = 1'b0;
    @(negedge clk);
    checks++;
    if (obs1 !== 12'h000) $display("FAIL start_with_rst_discarded: got %h expected %h", obs1, 12'h000);
    else passed++;
  endtask

  task automatic test_single_word();
    int dc;
    dc = 0;
    mem[3] = 16'h1A2F;
    build(8, 2, 4'd3, 4'd1, last1);
    start1 = 1'b1; base1 = 4'd3; cnt1 = 4'd1;
    for (int c = 1; c <= exp_q.size(); c++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (done1 === 1'b1 && dc == 0) dc = c;
      checks++;
      if (obs1 !== exp_q[c-1]) $display("FAIL single_word cycle %0d: got %h expected %h", c, obs1, exp_q[c-1]);
      else passed++;
    end
    checks++;
    if (dc != 43) $display("FAIL single_word_done_cycle: got %0d expected 43", dc);
    else passed++;
  endtask

  task automatic test_wrap();
    int dc;
    dc = 0;
    fill_mem_random();
    build(8, 2, 4'd15, 4'd2, last1);
    start1 = 1'b1; base1 = 4'd15; cnt1 = 4'd2;
    for (int c = 1; c <= exp_q.size(); c++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (done1 === 1'b1 && dc == 0) dc = c;
      checks++;
      if (obs1 !== exp_q[c-1]) $display("FAIL wrap cycle %0d: got %h expected %h", c, obs1, exp_q[c-1]);
      else passed++;
    end
    checks++;
    if (dc != 85) $display("FAIL wrap_done_cycle: got %0d expected 85", dc);
    else passed++;
  endtask

  task automatic test_zero_count();
    int reads;
    reads = 0;
    build(8, 2, 4'd5, 4'd0, last1);
    start1 = 1'b1; base1 = 4'd5; cnt1 = 4'd0;
    for (int c = 1; c <= exp_q.size() + 2; c++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (rd_en1 !== 1'b0) reads++;
      if (c <= exp_q.size()) begin
        checks++;
        if (obs1 !== exp_q[c-1]) $display("FAIL zero_count cycle %0d: got %h expected %h", c, obs1, exp_q[c-1]);
        else passed++;
      end
    end
    checks++;
    if (reads != 0) $display("FAIL zero_count_reads: got %0d expected 0", reads);
    else passed++;
  endtask

  task automatic test_start_while_busy();
    logic [3:0] b, b2;
    int dones;
    dones = 0;
    fill_mem_random();
    b  = 4'($urandom);
    b2 = b + 4'd6;
    build(8, 2, b, 4'd1, last1);
    start1 = 1'b1; base1 = b; cnt1 = 4'd1;
    for (int c = 1; c <= exp_q.size(); c++) begin
      @(negedge clk);
      if (done1 === 1'b1) dones++;
      checks++;
      if (obs1 !== exp_q[c-1]) $display("FAIL busy_ignore cycle %0d: got %h expected %h", c, obs1, exp_q[c-1]);
      else passed++;
      if (c == 5 || c == 43) begin
        start1 = 1'b1; base1 = b + 4'd3; cnt1 = 4'd2;
      end else begin
        start1 = 1'b0; base1 = b + 4'd1; cnt1 = 4'd3;
      end
    end
    checks++;
    if (dones != 1) $display("FAIL busy_single_done: got %0d expected 1", dones);
    else passed++;
    // Cycle 44 is idle: this start must be accepted
    build(8, 2, b2, 4'd1, last1);
    start1 = 1'b1; base1 = b2; cnt1 = 4'd1;
    for (int c = 1; c <= exp_q.size(); c++) begin
      @(negedge clk);
      start1 = 1'b0;
      checks++;
      if (obs1 !== exp_q[c-1]) $display("FAIL start_after_done cycle %0d: got %h expected %h", c, obs1, exp_q[c-1]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_show();
    logic [3:0] b;
    fill_mem_random();
    b = 4'($urandom);
    build(8, 2, b, 4'd1, last1);
    start1 = 1'b1; base1 = b; cnt1 = 4'd1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      start1 = 1'b0;
      checks++;
      if (obs1 !== exp_q[c-1]) $display("FAIL pre_reset cycle %0d: got %h expected %h", c, obs1, exp_q[c-1]);
      else passed++;
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (obs1 !== 12'h000) $display("FAIL mid_show_reset: got %h expected %h", obs1, 12'h000);
    else passed++;
    rst = 1'b0;
    last1 = 4'd0;
    last2 = 4'd0;
    @(negedge clk);
    checks++;
    if (obs1 !== 12'h000) $display("FAIL post_reset_idle: got %h expected %h", obs1, 12'h000);
    else passed++;
    build(8, 2, b, 4'd1, last1);
    start1 = 1'b1;
    for (int c = 1; c <= exp_q.size(); c++) begin
      @(negedge clk);
      start1 = 1'b0;
      checks++;
      if (obs1 !== exp_q[c-1]) $display("FAIL replay cycle %0d: got %h expected %h", c, obs1, exp_q[c-1]);
      else passed++;
    end
  endtask

  task automatic test_gap0();
    int dc;
    dc = 0;
    mem[6] = 16'h4321;
    build(1, 0, 4'd6, 4'd1, last2);
    start2 = 1'b1; base2 = 4'd6; cnt2 = 4'd1;
    for (int c = 1; c <= exp_q.size(); c++) begin
      @(negedge clk);
      start2 = 1'b0;
      if (done2 === 1'b1 && dc == 0) dc = c;
      checks++;
      if (obs2 !== exp_q[c-1]) $display("FAIL gap0 cycle %0d: got %h expected %h", c, obs2, exp_q[c-1]);
      else passed++;
    end
    checks++;
    if (dc != 7) $display("FAIL gap0_done_cycle: got %0d expected 7", dc);
    else passed++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      logic [3:0] b, n;
      logic       fast;
      fill_mem_random();
      b    = 4'($urandom);
      fast = it[0];
      if (fast) begin
        n = 4'($urandom_range(0, 6));
        build(1, 0, b, n, last2);
        start2 = 1'b1; base2 = b; cnt2 = n;
      end else begin
        n = 4'($urandom_range(0, 3));
        build(8, 2, b, n, last1);
        start1 = 1'b1; base1 = b; cnt1 = n;
      end
      for (int c = 1; c <= exp_q.size(); c++) begin
        @(negedge clk);
        start1 = 1'b0; start2 = 1'b0;
        base1 = 4'($urandom); cnt1 = 4'($urandom);
        base2 = 4'($urandom); cnt2 = 4'($urandom);
        checks++;
        if ((fast ? obs2 : obs1) !== exp_q[c-1])
          $display("FAIL random it %0d cycle %0d: got %h expected %h", it, c, fast ? obs2 : obs1, exp_q[c-1]);
        else passed++;
      end
    end
  endtask

  initial begin
    checks = 0; passed = 0;
    last1 = 4'd0; last2 = 4'd0;
    rst = 1'b1;
    start1 = 1'b0; start2 = 1'b0;
    base1 = 4'd0; cnt1 = 4'd0; base2 = 4'd0; cnt2 = 4'd0;
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    test_reset();
    test_single_word();
    test_wrap();
    test_zero_count();
    test_start_while_busy();
    test_reset_mid_show();
    test_gap0();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
